// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT size constants, sequencer states and address bit-reversal
package fft_pkg;
    localparam int LOG2N = 4;
    localparam int N = 1 << LOG2N;
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, UNLOAD, FIN} state_t;
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        return {<<{v}};
    endfunction
endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: maps (stage, butterfly index) to radix-2 DIT operand and twiddle addresses
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [2:0]       s,
    input  logic [LOG2N-2:0] b,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr
);
    logic [LOG2N-1:0] bx, span, mask, pos;
    // grp*2*span+pos is b with a zero bit inserted at position s
    always_comb begin
        bx = {1'b0, b};
        span = LOG2N'(1) << s;
        mask = span - LOG2N'(1);
        pos = bx & mask;
        rd_addr_a = ((bx & ~mask) << 1) | pos;
        rd_addr_b = rd_addr_a | span;
        tw_addr = (LOG2N-1)'(pos << (3'(LOG2N - 1) - s));
    end
endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: sequences bit-reversed load, LOG2N butterfly stages and natural-order unload
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int BF_LATENCY = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ld_we,
    output logic [LOG2N-1:0] ld_addr,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_issue,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [2:0]       stage
);
    localparam int CYC = N / 2 + BF_LATENCY;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] stage_q, stage_d;
    logic ov_q, ov_d, unload;
    logic [BF_LATENCY-1:0] wv_q, wv_d;
    logic [LOG2N-1:0] wa_q [BF_LATENCY];
    logic [LOG2N-1:0] wa_d [BF_LATENCY];
    logic [LOG2N-1:0] wb_q [BF_LATENCY];
    logic [LOG2N-1:0] wb_d [BF_LATENCY];
    logic [LOG2N-1:0] gen_a, gen_b;
    logic [LOG2N-2:0] gen_tw;

    fft_addr_gen u_addr (
        .s(stage_q),
        .b(cnt_q[LOG2N-2:0]),
        .rd_addr_a(gen_a),
        .rd_addr_b(gen_b),
        .tw_addr(gen_tw)
    );

    assign wr_en = wv_q[BF_LATENCY-1];
    assign wr_addr_a = wa_q[BF_LATENCY-1];
    assign wr_addr_b = wb_q[BF_LATENCY-1];
    assign stage = stage_q;
    assign out_valid = ov_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        stage_d = stage_q;
        ov_d = ov_q;
        busy = state_q != IDLE;
        done = state_q == FIN;
        in_ready = state_q == LOAD;
        unload = state_q == UNLOAD;
        ld_we = in_ready & in_valid;
        ld_addr = in_ready ? bitrev(cnt_q[LOG2N-1:0]) : '0;
        // each stage is N/2 issue cycles followed by BF_LATENCY drain cycles
        bf_issue = state_q == COMPUTE && cnt_q < 8'(N / 2);
        rd_en = bf_issue | (unload && cnt_q < 8'(N) && (!ov_q || out_ready));
        rd_addr_a = bf_issue ? gen_a : unload ? cnt_q[LOG2N-1:0] : '0;
        rd_addr_b = bf_issue ? gen_b : '0;
        tw_addr = bf_issue ? gen_tw : '0;
        wv_d = BF_LATENCY'({wv_q, bf_issue});
        wa_d[0] = rd_addr_a;
        wb_d[0] = rd_addr_b;
        for (int i = 1; i < BF_LATENCY; i++) begin
            wa_d[i] = wa_q[i-1];
            wb_d[i] = wb_q[i-1];
        end
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                cnt_d = '0;
            end
            LOAD: if (in_valid) begin
                cnt_d = cnt_q == 8'(N - 1) ? '0 : cnt_q + 8'd1;
                state_d = cnt_q == 8'(N - 1) ? COMPUTE : LOAD;
            end
            COMPUTE: begin
                cnt_d = cnt_q == 8'(CYC - 1) ? '0 : cnt_q + 8'd1;
                if (cnt_q == 8'(CYC - 1)) begin
                    state_d = stage_q == 3'(LOG2N - 1) ? UNLOAD : COMPUTE;
                    stage_d = stage_q == 3'(LOG2N - 1) ? stage_q : stage_q + 3'd1;
                end
            end
            UNLOAD: begin
                cnt_d = rd_en ? cnt_q + 8'd1 : cnt_q;
                ov_d = rd_en ? 1'b1 : out_ready ? 1'b0 : ov_q;
                if (ov_q && out_ready && cnt_q == 8'(N)) begin
                    state_d = FIN;
                    cnt_d = '0;
                    ov_d = 1'b0;
                end
            end
            FIN: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            stage_q <= '0;
            ov_q <= 1'b0;
            wv_q <= '0;
            wa_q <= '{default: '0};
            wb_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            stage_q <= stage_d;
            ov_q <= ov_d;
            wv_q <= wv_d;
            wa_q <= wa_d;
            wb_q <= wb_d;
        end
    end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: randomized directed bench for fft_sequencer against an address-level FFT model
module tb_fft_sequencer;
    localparam int LAT = 3;
    localparam int NPT = 16;
    localparam int HALF = NPT / 2;
    localparam int CY = HALF + LAT;
    localparam bit PAT [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    typedef struct {int due; int a; int b;} wb_t;

    logic clock = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic busy, done, in_ready, out_valid, ld_we, rd_en, bf_issue, wr_en;
    logic [3:0] ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [2:0] tw_addr, stage;
    logic [31:0] rdata = '0;
    int n_cmp = 0, n_bad = 0, dcount = 0;
    bit ab;

    fft_sequencer #(.BF_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .ld_we(ld_we), .ld_addr(ld_addr), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .tw_addr(tw_addr), .bf_issue(bf_issue), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage)
    );

    always #5 clock = ~clock;

    // sample RAM stand-in: location i holds 100+i, one-cycle synchronous read
    always @(posedge clock) begin
        if (rd_en) rdata <= 32'd100 + 32'(rd_addr_a);
        if (done) dcount <= dcount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bitrev_m(input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) if (((k >> i) & 1) != 0) r += 1 << (3 - i);
        return r;
    endfunction

    task automatic kick();
        @(negedge clock);
        start = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    task automatic load_phase(input bit gaps);
        int k = 0, cyc = 0;
        while (k < NPT && cyc < 200) begin
            @(negedge clock);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = 1'($urandom_range(0, 1));
            #1;
            chk("load_in_ready", in_ready, 1);
            chk("load_busy", busy, 1);
            chk("ld_we", ld_we, in_valid);
            if (in_valid) begin
                chk("ld_addr", ld_addr, bitrev_m(k));
                k++;
            end
            cyc++;
        end
        chk("load_count", k, NPT);
    endtask

    task automatic compute_phase(input bit abort, output bit aborted);
        wb_t q[$];
        int t = 0, span, a, pos;
        logic exp_wr;
        aborted = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < CY; c++) begin
                @(negedge clock);
                start = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                #1;
                span = 1 << s;
                if (t == 0) chk("compute_in_ready", in_ready, 0);
                if (c == 0 && s > 0) chk("stage_barrier_pending", q.size(), 0);
                chk("compute_ld_we", ld_we, 0);
                chk("stage", stage, s);
                chk("bf_issue", bf_issue, c < HALF);
                chk("rd_en_compute", rd_en, c < HALF);
                exp_wr = q.size() > 0 && q[0].due == t;
                chk("wr_en", wr_en, exp_wr);
                if (exp_wr) begin
                    chk("wr_addr_a", wr_addr_a, q[0].a);
                    chk("wr_addr_b", wr_addr_b, q[0].b);
                    void'(q.pop_front());
                end
                if (c < HALF) begin
                    pos = c % span;
                    a = (c / span) * 2 * span + pos;
                    chk("rd_addr_a", rd_addr_a, a);
                    chk("rd_addr_b", rd_addr_b, a + span);
                    chk("tw_addr", tw_addr, pos * HALF / span);
                    q.push_back('{t + LAT, a, a + span});
                end
                if (abort && s == 2 && c == 5) begin
                    reset = 1'b1;
                    @(negedge clock);
                    #1;
                    chk("abort_busy", busy, 0);
                    chk("abort_wr_en", wr_en, 0);
                    chk("abort_out_valid", out_valid, 0);
                    chk("abort_stage", stage, 0);
                    reset = 1'b0;
                    start = 1'b0;
                    in_valid = 1'b0;
                    aborted = 1'b1;
                    return;
                end
                t++;
            end
        end
        chk("compute_drained", q.size(), 0);
    endtask

    task automatic unload_phase(input bit pat);
        int reads = 0, acc = 0, cyc = 0, d0 = dcount;
        bit m_ov = 1'b0;
        logic er;
        in_valid = 1'b0;
        while (acc < NPT && cyc < 300) begin
            @(negedge clock);
            out_ready = pat ? PAT[cyc % 4] : 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) begin
                chk("unload_stage", stage, 3);
                chk("unload_bf_issue", bf_issue, 0);
            end
            chk("unload_wr_en", wr_en, 0);
            chk("unload_busy", busy, 1);
            chk("out_valid", out_valid, m_ov);
            er = reads < NPT && (!m_ov || out_ready);
            chk("unload_rd_en", rd_en, er);
            if (reads < NPT) chk("unload_rd_addr", rd_addr_a, reads);
            if (m_ov && out_ready) begin
                chk("out_sample", rdata, 100 + acc);
                acc++;
            end
            if (er) reads++;
            m_ov = er ? 1'b1 : out_ready ? 1'b0 : m_ov;
            cyc++;
        end
        chk("accepted", acc, NPT);
        @(negedge clock);
        out_ready = 1'($urandom_range(0, 1));
        start = 1'b1;
        #1;
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        chk("fin_out_valid", out_valid, 0);
        chk("fin_rd_en", rd_en, 0);
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("idle_done", done, 0);
        chk("idle_busy_after_fin", busy, 0);
        chk("idle_stage", stage, 0);
        @(negedge clock);
        #1;
        chk("fin_start_ignored", busy, 0);
        chk("done_pulses", dcount - d0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ld_we", ld_we, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_bf_issue", bf_issue, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_stage", stage, 0);
        chk("rst_addrs", {rd_addr_a, rd_addr_b, tw_addr, ld_addr}, 0);
        reset = 1'b0;

        kick();
        load_phase(1'b0);
        compute_phase(1'b1, ab);
        chk("aborted", ab, 1);
        repeat (4) begin
            @(negedge clock);
            #1;
            chk("post_abort_wr_en", wr_en, 0);
            chk("post_abort_busy", busy, 0);
        end

        kick();
        load_phase(1'b1);
        compute_phase(1'b0, ab);
        unload_phase(1'b1);

        kick();
        load_phase(1'b1);
        compute_phase(1'b0, ab);
        unload_phase(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
